// File: rtl/cr_ahbl_sram_slv.sv
// AHB-Lite responder mapping bus transfers onto a single-port SRAM with one-cycle read latency.
// Define CR_AHBL_SLV_ALIGN_CHK_EN to enable size/alignment checking with two-cycle ERROR responses.
module cr_ahbl_sram_slv #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  ahbl_gated_clk,
  input  logic                  cpurst_b,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [3:0]            hprot,
  input  logic [2:0]            hburst,
  input  logic [31:0]           hwdata,
  input  logic                  hready_in,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  slv_idle
);

  localparam int unsigned WORD_AW  = ADDR_WIDTH - 2;
  localparam logic [1:0]  WAIT_LD  = 2'(WAIT_CYCLES);
  localparam logic [1:0]  SIZE_WRD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
    ST_ERR1 = 3'd5,
    ST_ERR2 = 3'd6,
`endif
    ST_RDV  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;

  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic                   mem_cen_q, mem_cen_d;
  logic                   mem_wen_q, mem_wen_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [WORD_AW-1:0]     mem_addr_q, mem_addr_d;
  logic                   slv_idle_q, slv_idle_d;

  logic                   accept_c;
  logic [1:0]             size_in_c;
  logic [3:0]             be_c;
`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
  logic                   illegal_c;
`endif

  // Protection/burst attributes and alias address bits carry no meaning for a flat SRAM
  logic unused_ok;
  assign unused_ok = ^{hprot, hburst, htrans[0], haddr[31:ADDR_WIDTH]};

  assign accept_c  = hsel & htrans[1] & hready_in;
  // Oversized transfers collapse to a word when the checker is not built
  assign size_in_c = (hsize > 3'd2) ? SIZE_WRD : hsize[1:0];

`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
  assign illegal_c = (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`endif

  // Next state, captured address phase, and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    mem_cen_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_be_d    = 4'h0;
    mem_addr_d  = '0;
    slv_idle_d  = 1'b0;
    be_c        = 4'hF;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = write_q ? ST_WR : ST_RD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RD:   state_d = ST_RDV;
`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // IDLE, WR, RDV and ERR2 complete this cycle, so a new address phase may be taken
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d  = haddr[ADDR_WIDTH-1:0];
          write_d = hwrite;
          size_d  = size_in_c;
          cnt_d   = WAIT_LD;
          if (WAIT_LD != 2'd0) state_d = ST_WAIT;
          else                 state_d = hwrite ? ST_WR : ST_RD;
`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
          if (illegal_c) state_d = ST_ERR1;
`endif
        end
      end
    endcase

    case (size_d)
      2'd0:    be_c = 4'b0001 << addr_d[1:0];
      2'd1:    be_c = addr_d[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase

    case (state_d)
      ST_IDLE: slv_idle_d = 1'b1;
      ST_WAIT: hreadyout_d = 1'b0;
      ST_WR: begin
        mem_cen_d  = 1'b1;
        mem_wen_d  = 1'b1;
        mem_be_d   = be_c;
        mem_addr_d = addr_d[ADDR_WIDTH-1:2];
      end
      ST_RD: begin
        hreadyout_d = 1'b0;
        mem_cen_d   = 1'b1;
        mem_be_d    = 4'hF;
        mem_addr_d  = addr_d[ADDR_WIDTH-1:2];
      end
`ifdef CR_AHBL_SLV_ALIGN_CHK_EN
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: hresp_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      mem_cen_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      slv_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      mem_cen_q   <= mem_cen_d;
      mem_wen_q   <= mem_wen_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      slv_idle_q  <= slv_idle_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign mem_cen   = mem_cen_q;
  assign mem_wen   = mem_wen_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign slv_idle  = slv_idle_q;

  // Write data arrives in the data phase and read data one cycle after RD, so both pass straight through
  assign mem_wdata = (state_q == ST_WR)  ? hwdata    : 32'h0;
  assign hrdata    = (state_q == ST_RDV) ? mem_rdata : 32'h0;

endmodule
